// File: rtl/apb_arbiter.sv
// Round-robin APB requester: arbitrates N valid/ready command ports onto one APB completer,
// runs SETUP/ACCESS with wait states, and aborts stalled transfers with a watchdog.
module apb_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            apb_pclk,
  input  logic            nreset,
  input  logic [N-1:0]    req_valid,
  input  logic [N-1:0]    req_write,
  input  logic [N*AW-1:0] req_addr,
  input  logic [N*DW-1:0] req_wdata,
  output logic [N-1:0]    req_ready,
  output logic [N-1:0]    rsp_valid,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err,
  output logic            apb_psel,
  output logic            apb_penable,
  output logic            apb_pwrite,
  output logic [AW-1:0]   apb_paddr,
  output logic [DW-1:0]   apb_pwdata,
  output logic [3:0]      apb_pstrb,
  output logic [2:0]      apb_pprot,
  input  logic            apb_pready,
  input  logic [DW-1:0]   apb_prdata
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned WdW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   last_q, last_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic              pwrite_q, pwrite_d;
  logic [AW-1:0]     paddr_q, paddr_d;
  logic [DW-1:0]     pwdata_q, pwdata_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic [WdW-1:0]    wd_q, wd_d;
  logic [N-1:0]      rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic              win_found;
  logic [IdxW-1:0]   win_idx;
  int unsigned       cand;

  // Search starts one past the last grant so every requester gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = (32'(last_q) + k) % N;
      if (!win_found && req_valid[IdxW'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IdxW'(cand);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == StIdle && win_found) req_ready[win_idx] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    wd_d        = wd_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d  = StSetup;
          last_d   = win_idx;
          owner_d  = win_idx;
          pwrite_d = req_write[win_idx];
          paddr_d  = req_addr[win_idx*AW +: AW];
          pwdata_d = req_wdata[win_idx*DW +: DW];
        end
      end
      StSetup: begin
        state_d = StAccess;
        wd_d    = '0;
      end
      StAccess: begin
        if (apb_pready) begin
          state_d              = StIdle;
          wd_d                 = '0;
          rsp_valid_d[owner_q] = 1'b1;
          rsp_rdata_d          = pwrite_q ? '0 : apb_prdata;
          rsp_err_d            = 1'b0;
        end else if (TIMEOUT != 0 && wd_q == WdLast) begin
          state_d              = StIdle;
          wd_d                 = '0;
          rsp_valid_d[owner_q] = 1'b1;
          rsp_rdata_d          = '0;
          rsp_err_d            = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    psel_d    = (state_d != StIdle);
    penable_d = (state_d == StAccess);
  end

  always_ff @(posedge apb_pclk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= StIdle;
      last_q      <= IdxW'(N - 1);
      owner_q     <= '0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      wd_q        <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      wd_q        <= wd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign apb_psel    = psel_q;
  assign apb_penable = penable_q;
  assign apb_pwrite  = pwrite_q;
  assign apb_paddr   = paddr_q;
  assign apb_pwdata  = pwdata_q;
  assign apb_pstrb   = 4'b1111;
  assign apb_pprot   = 3'b000;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_apb_arbiter.sv
// Bench for apb_arbiter: directed scenarios plus random transactions checked against a
// transaction-level round-robin / APB timing model.
module tb_apb_arbiter;
  localparam int N       = 4;
  localparam int DW      = 32;
  localparam int AW      = 5;
  localparam int TIMEOUT = 16;

  logic            clk;
  logic            nreset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic            apb_psel;
  logic            apb_penable;
  logic            apb_pwrite;
  logic [AW-1:0]   apb_paddr;
  logic [DW-1:0]   apb_pwdata;
  logic [3:0]      apb_pstrb;
  logic [2:0]      apb_pprot;
  logic            apb_pready;
  logic [DW-1:0]   apb_prdata;

  int checks   = 0;
  int failures = 0;
  int last_g   = N - 1;
  logic [N-1:0] grant_seen;

  apb_arbiter #(.N(N), .DW(DW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .apb_pclk   (clk),
    .nreset     (nreset),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .apb_psel   (apb_psel),
    .apb_penable(apb_penable),
    .apb_pwrite (apb_pwrite),
    .apb_paddr  (apb_paddr),
    .apb_pwdata (apb_pwdata),
    .apb_pstrb  (apb_pstrb),
    .apb_pprot  (apb_pprot),
    .apb_pready (apb_pready),
    .apb_prdata (apb_prdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] one;
    one = 1;
    return one << i;
  endfunction

  // Round robin: first valid requester strictly after the previous grant, wrapping.
  function automatic int exp_winner(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic randomize_reqs();
    for (int i = 0; i < N; i++) begin
      req_write[i]           = 1'($urandom_range(0, 1));
      req_addr[i*AW +: AW]   = AW'($urandom);
      req_wdata[i*DW +: DW]  = $urandom;
    end
  endtask

  // One complete transfer: accept, SETUP, ACCESS (waits or watchdog), response, hold.
  task automatic run_txn(input logic [N-1:0] valid, input int waits, input bit tmo,
                         input logic [DW-1:0] rd, output logic [N-1:0] seen);
    int w;
    logic wr;
    logic [AW-1:0] ad;
    logic [DW-1:0] wd;
    logic [DW-1:0] exp_rd;
    bit done;
    w = exp_winner(valid, last_g);
    @(negedge clk);
    req_valid  = valid;
    apb_pready = 1'b0;
    #1;
    seen = req_ready;
    chk("accept_ready", 32'(req_ready), 32'(oh(w)));
    chk("accept_psel", 32'(apb_psel), 0);
    chk("accept_rsp", 32'(rsp_valid), 0);
    last_g = w;
    wr = req_write[w];
    ad = req_addr[w*AW +: AW];
    wd = req_wdata[w*DW +: DW];
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("setup_psel", 32'(apb_psel), 1);
    chk("setup_penable", 32'(apb_penable), 0);
    chk("setup_paddr", 32'(apb_paddr), 32'(ad));
    chk("setup_pwrite", 32'(apb_pwrite), 32'(wr));
    chk("setup_pwdata", apb_pwdata, wd);
    chk("setup_ready", 32'(req_ready), 0);
    done = 1'b0;
    for (int c = 0; c < TIMEOUT + 8 && !done; c++) begin
      @(negedge clk);
      apb_pready = !tmo && (c == waits);
      apb_prdata = apb_pready ? rd : (32'hDEAD0000 | 32'(c));
      #1;
      chk("access_psel", 32'(apb_psel), 1);
      chk("access_penable", 32'(apb_penable), 1);
      chk("access_paddr", 32'(apb_paddr), 32'(ad));
      chk("access_pwrite", 32'(apb_pwrite), 32'(wr));
      chk("access_pwdata", apb_pwdata, wd);
      chk("access_rsp", 32'(rsp_valid), 0);
      if (apb_pready || (tmo && c == TIMEOUT - 1)) done = 1'b1;
    end
    chk("access_bound", 32'(done), 1);
    @(negedge clk);
    apb_pready = 1'b0;
    #1;
    exp_rd = (tmo || wr) ? '0 : rd;
    chk("rsp_valid", 32'(rsp_valid), 32'(oh(w)));
    chk("rsp_err", 32'(rsp_err), 32'(tmo));
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_psel", 32'(apb_psel), 0);
    chk("rsp_penable", 32'(apb_penable), 0);
    @(negedge clk);
    #1;
    chk("hold_rsp_valid", 32'(rsp_valid), 0);
    chk("hold_rdata", rsp_rdata, exp_rd);
    chk("hold_err", 32'(rsp_err), 32'(tmo));
  endtask

  initial begin
    int w;
    int prev;
    int phase;
    logic [N-1:0] v;
    nreset     = 1'b0;
    req_valid  = '0;
    req_write  = '0;
    req_addr   = '0;
    req_wdata  = '0;
    apb_pready = 1'b0;
    apb_prdata = '0;
    #2;
    chk("rst_psel", 32'(apb_psel), 0);
    chk("rst_penable", 32'(apb_penable), 0);
    chk("rst_pwrite", 32'(apb_pwrite), 0);
    chk("rst_paddr", 32'(apb_paddr), 0);
    chk("rst_pwdata", apb_pwdata, 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", 32'(rsp_err), 0);
    chk("rst_pstrb", 32'(apb_pstrb), 32'hF);
    chk("rst_pprot", 32'(apb_pprot), 0);
    @(negedge clk);
    nreset = 1'b1;

    // All requesters valid: strict rotation, one accept every three cycles.
    apb_pready = 1'b1;
    prev = -1;
    for (int cyc = 0; cyc < 24; cyc++) begin
      @(negedge clk);
      req_valid  = '1;
      apb_prdata = 32'hB0000000 | 32'(cyc);
      #1;
      phase = cyc % 3;
      if (phase == 0) begin
        w = exp_winner('1, last_g);
        chk("rr_ready", 32'(req_ready), 32'(oh(w)));
        if (prev >= 0) begin
          chk("rr_rsp", 32'(rsp_valid), 32'(oh(prev)));
          chk("rr_rdata", rsp_rdata, 32'hB0000000 | 32'(cyc - 1));
        end else begin
          chk("rr_rsp_first", 32'(rsp_valid), 0);
        end
        prev   = w;
        last_g = w;
      end else begin
        chk("rr_idle_ready", 32'(req_ready), 0);
      end
      chk("rr_psel", 32'(apb_psel), 32'(phase != 0));
      chk("rr_penable", 32'(apb_penable), 32'(phase == 2));
    end
    @(negedge clk);
    req_valid  = '0;
    apb_pready = 1'b0;
    #1;
    chk("rr_last_rsp", 32'(rsp_valid), 32'(oh(prev)));

    // Single read from requester 0.
    req_write = '0;
    req_addr[0 +: AW] = 5'h03;
    run_txn(4'b0001, 0, 1'b0, 32'hCAFE0003, grant_seen);

    // Write with three wait states.
    req_write[1] = 1'b1;
    req_addr[1*AW +: AW] = 5'h1F;
    req_wdata[1*DW +: DW] = 32'h12345678;
    run_txn(4'b0010, 3, 1'b0, 32'h55AA55AA, grant_seen);

    // Watchdog abort, then the next requester in rotation is served.
    randomize_reqs();
    run_txn(4'b1100, 0, 1'b1, 32'h0BADF00D, grant_seen);
    run_txn(4'b1111, 1, 1'b0, 32'h600DF00D, grant_seen);

    // Randomized traffic.
    for (int t = 0; t < 30; t++) begin
      randomize_reqs();
      v = N'($urandom_range(1, (1 << N) - 1));
      run_txn(v, $urandom_range(0, 3), ($urandom_range(0, 7) == 0), $urandom, grant_seen);
    end

    // Reset during ACCESS: bus drops at once, no response, requester 0 wins afterwards.
    req_write = '0;
    @(negedge clk);
    req_valid = 4'b0100;
    #1;
    chk("mid_accept", 32'(req_ready), 32'(oh(exp_winner(4'b0100, last_g))));
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    apb_pready = 1'b0;
    #1;
    chk("mid_penable", 32'(apb_penable), 1);
    #1;
    nreset = 1'b0;
    #1;
    chk("mid_rst_psel", 32'(apb_psel), 0);
    chk("mid_rst_penable", 32'(apb_penable), 0);
    chk("mid_rst_rsp", 32'(rsp_valid), 0);
    last_g = N - 1;
    @(negedge clk);
    nreset = 1'b1;
    #1;
    chk("post_rst_rsp", 32'(rsp_valid), 0);
    run_txn(4'b1111, 0, 1'b0, 32'h0000A5A5, grant_seen);
    chk("post_rst_grant0", 32'(grant_seen), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
